// File: rtl/rlwe_pkg.sv
// Shared constants, FSM state type and coefficient decode helper for the RLWE decode stage.
package rlwe_pkg;
  localparam int Q      = 10;
  localparam int N      = 4;
  localparam int IDX_W  = $clog2(N);
  localparam int MARG_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, PROC, PUSH} state_t;

  // Top three bits of d within 2^(q-3) of a decision boundary.
  localparam logic [2:0] MARG_PAT_A = 3'b001;
  localparam logic [2:0] MARG_PAT_B = 3'b010;
  localparam logic [2:0] MARG_PAT_C = 3'b101;
  localparam logic [2:0] MARG_PAT_D = 3'b110;

  typedef struct packed {
    logic msg_bit;
    logic marg;
  } dec_t;

  // msg_bit set iff d lies in [2^q/4, 3*2^q/4), i.e. the two top bits differ.
  function automatic dec_t decode_coef(input logic [2:0] top);
    dec_t r;
    r.msg_bit = top[2] ^ top[1];
    r.marg    = (top == MARG_PAT_A) || (top == MARG_PAT_B) ||
                (top == MARG_PAT_C) || (top == MARG_PAT_D);
    return r;
  endfunction
endpackage

// File: rtl/msg_fifo2.sv
// Two-entry synchronous FIFO; head is registered and reads as zero when empty.
// A push while full is accepted only when a pop happens in the same cycle.
module msg_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push_en;
  logic         pop_en;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      // When full, wr_ptr == rd_ptr: overwriting the slot being popped is safe.
      if (push_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_en) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push_en} - {1'b0, pop_en};
    end
  end
endmodule

// File: rtl/rlwe_decode.sv
// Decodes d = v - p mod 2^q per coefficient into message bits plus a marginal count.
// One coefficient per cycle; words queue in a 2-entry FIFO that stalls the FSM when full.
module rlwe_decode #(
  parameter int N = rlwe_pkg::N,
  parameter int q = rlwe_pkg::Q
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [q-1:0]               p_0,
  input  logic [q-1:0]               p_1,
  input  logic [q-1:0]               p_2,
  input  logic [q-1:0]               p_3,
  input  logic [q-1:0]               v_0,
  input  logic [q-1:0]               v_1,
  input  logic [q-1:0]               v_2,
  input  logic [q-1:0]               v_3,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [N-1:0]               msg,
  output logic [rlwe_pkg::MARG_W-1:0] msg_marg
);
  import rlwe_pkg::*;

  state_t               state, state_nxt;
  logic [q-1:0]         p_r [N];
  logic [q-1:0]         v_r [N];
  logic [IDX_W-1:0]     k;
  logic [N-1:0]         bits_acc;
  logic [MARG_W-1:0]    marg_acc;
  logic [q-1:0]         d;
  dec_t                 dec;
  logic                 capture;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [N+MARG_W-1:0]  fifo_dout;
  logic                 unused_d_low;

  // Subtraction wraps naturally at q bits; only the top three bits decide.
  assign d            = v_r[k] - p_r[k];
  assign dec          = decode_coef(d[q-1 -: 3]);
  assign unused_d_low = ^d[q-4:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    capture   = 1'b0;
    fifo_push = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = PROC;
        end
      end
      PROC: if (k == IDX_W'(N - 1)) state_nxt = PUSH;
      PUSH: if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      bits_acc <= '0;
      marg_acc <= '0;
      for (int i = 0; i < N; i++) begin
        p_r[i] <= '0;
        v_r[i] <= '0;
      end
    end else if (capture) begin
      k        <= '0;
      bits_acc <= '0;
      marg_acc <= '0;
      p_r[0] <= p_0; p_r[1] <= p_1; p_r[2] <= p_2; p_r[3] <= p_3;
      v_r[0] <= v_0; v_r[1] <= v_1; v_r[2] <= v_2; v_r[3] <= v_3;
    end else if (state == PROC) begin
      bits_acc[k] <= dec.msg_bit;
      marg_acc    <= marg_acc + MARG_W'(dec.marg);
      k           <= k + 1'b1;
    end
  end

  assign fifo_pop  = !fifo_empty && msg_ready;
  assign msg_valid = !fifo_empty;
  assign msg       = fifo_dout[MARG_W +: N];
  assign msg_marg  = fifo_dout[MARG_W-1:0];

  msg_fifo2 #(.W(N + MARG_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({bits_acc, marg_acc}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );
endmodule

// File: tb/tb_rlwe_decode.sv
// Directed bench for rlwe_decode: vector table plus reset, back-pressure and mid-frame reset sequences.
module tb_rlwe_decode;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] p_0, p_1, p_2, p_3;
  logic [9:0] v_0, v_1, v_2, v_3;
  logic       msg_valid;
  logic       msg_ready;
  logic [3:0] msg;
  logic [2:0] msg_marg;

  typedef struct packed {
    logic [3:0][9:0] v;
    logic [3:0][9:0] p;
    logic [3:0]      msg;
    logic [2:0]      marg;
  } vec_t;

  vec_t vecs [5];
  int   n_chk  = 0;
  int   n_fail = 0;

  rlwe_decode dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_0(p_0), .p_1(p_1), .p_2(p_2), .p_3(p_3),
    .v_0(v_0), .v_1(v_1), .v_2(v_2), .v_3(v_3),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg(msg), .msg_marg(msg_marg)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int v0, int v1, int v2, int v3,
                              int p0, int p1, int p2, int p3, int m, int mg);
    vec_t t;
    t.v[0] = 10'(v0); t.v[1] = 10'(v1); t.v[2] = 10'(v2); t.v[3] = 10'(v3);
    t.p[0] = 10'(p0); t.p[1] = 10'(p1); t.p[2] = 10'(p2); t.p[3] = 10'(p3);
    t.msg  = 4'(m);
    t.marg = 3'(mg);
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    v_0 = t.v[0]; v_1 = t.v[1]; v_2 = t.v[2]; v_3 = t.v[3];
    p_0 = t.p[0]; p_1 = t.p[1]; p_2 = t.p[2]; p_3 = t.p[3];
  endtask

  task automatic send(input vec_t t);
    int w = 0;
    while (!in_ready && w < 40) begin
      tick;
      w++;
    end
    chk("send_in_ready", int'(in_ready), 1);
    drive(t);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  // Waits for a word, checks it (and latency when lat >= 0), then pops it.
  task automatic expect_word(input string name, input vec_t t, input int lat);
    int w = 0;
    while (!msg_valid && w < 20) begin
      tick;
      w++;
    end
    chk({name, "_valid"}, int'(msg_valid), 1);
    if (lat >= 0) chk({name, "_latency"}, w, lat);
    chk({name, "_msg"}, int'(msg), int'(t.msg));
    chk({name, "_marg"}, int'(msg_marg), int'(t.marg));
    msg_ready = 1'b1;
    tick;
    msg_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(512, 0, 300, 700,   0, 0,   0,   0, 'b1101, 2);
    vecs[1] = mk(100, 0,   0,   0, 900, 0,   0,   0, 'b0000, 1);
    vecs[2] = mk(255, 256, 767, 768, 0, 0,   0,   0, 'b0110, 4);
    vecs[3] = mk(137, 133, 895,   0, 10, 5,  0, 128, 'b0000, 2);
    vecs[4] = mk(0,   384, 1000, 511, 1, 0, 360,  0, 'b1110, 1);

    // Reset held with a frame offered: nothing may be captured.
    rst = 1'b1;
    in_valid = 1'b1;
    msg_ready = 1'b0;
    drive(vecs[0]);
    tick;
    tick;
    chk("rst_msg_valid", int'(msg_valid), 0);
    chk("rst_msg", int'(msg), 0);
    chk("rst_msg_marg", int'(msg_marg), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("post_rst_in_ready", int'(in_ready), 1);
    repeat (8) tick;
    chk("rst_no_capture", int'(msg_valid), 0);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i]);
      expect_word($sformatf("vec%0d", i), vecs[i], 5);
    end

    // Back-pressure: two words buffered, third frame parked in PUSH.
    msg_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    send(vecs[2]);
    repeat (7) tick;
    drive(vecs[3]);
    in_valid = 1'b1;
    begin
      int ir_hi = 0;
      repeat (4) begin
        if (in_ready) ir_hi++;
        tick;
      end
      chk("bp_in_ready_low", ir_hi, 0);
    end
    chk("bp_valid", int'(msg_valid), 1);
    chk("bp_head0", int'(msg), int'(vecs[0].msg));
    chk("bp_head0_marg", int'(msg_marg), int'(vecs[0].marg));
    // Pop while full and stalled in PUSH: write and pop share the edge.
    msg_ready = 1'b1;
    tick;
    chk("bp_head1", int'(msg), int'(vecs[1].msg));
    chk("bp_head1_marg", int'(msg_marg), int'(vecs[1].marg));
    chk("bp_in_ready_back", int'(in_ready), 1);
    msg_ready = 1'b0;
    tick;
    chk("bp_frame4_taken", int'(in_ready), 0);
    chk("bp_head1_held", int'(msg_marg), int'(vecs[1].marg));
    in_valid = 1'b0;
    msg_ready = 1'b1;
    tick;
    chk("bp_head2_valid", int'(msg_valid), 1);
    chk("bp_head2", int'(msg), int'(vecs[2].msg));
    chk("bp_head2_marg", int'(msg_marg), int'(vecs[2].marg));
    tick;
    chk("bp_drained", int'(msg_valid), 0);
    msg_ready = 1'b0;
    expect_word("bp_frame4", vecs[3], -1);

    // Reset at k=2 with one word already buffered.
    send(vecs[4]);
    begin
      int w = 0;
      while (!msg_valid && w < 20) begin
        tick;
        w++;
      end
    end
    chk("mid_buffered", int'(msg_valid), 1);
    send(vecs[1]);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_valid", int'(msg_valid), 0);
    chk("mid_rst_msg", int'(msg), 0);
    chk("mid_rst_marg", int'(msg_marg), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    repeat (8) tick;
    chk("mid_rst_discard", int'(msg_valid), 0);
    send(vecs[2]);
    expect_word("after_rst", vecs[2], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
